// File: rtl/tokenflow_arbiter.sv
// Two-requester four-phase bundled-data arbiter onto one shared output channel.
// Define TOKENFLOW_ARBITER_SYNC_EN to add two-flop synchronizers on a_req/b_req/o_ack.
module tokenflow_arbiter #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req,
  input  logic [W-1:0] a_data,
  output logic         a_ack,
  input  logic         b_req,
  input  logic [W-1:0] b_data,
  output logic         b_ack,
  output logic         o_req,
  output logic [W-1:0] o_data,
  input  logic         o_ack
);

  typedef enum logic [1:0] {
    IDLE,
    OREQ,
    SACK,
    OREL
  } state_t;

  // Requester identity: 0 = A, 1 = B.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t         r_state;
  logic           r_g;
  logic           r_last;
  logic           r_oreq;
  logic           r_aack;
  logic           r_back;
  logic [W-1:0]   r_odata;

  logic [2:0]     w_s;
  logic           w_s_a;
  logic           w_s_b;
  logic           w_s_oack;
  logic           w_any;
  logic           w_pick_b;
  logic           w_g_req;

`ifdef TOKENFLOW_ARBITER_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {o_ack, b_req, a_req};
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = {o_ack, b_req, a_req};
`endif

  assign w_s_a    = w_s[0];
  assign w_s_b    = w_s[1];
  assign w_s_oack = w_s[2];
  assign w_any    = w_s_a | w_s_b;

  // On a tie the requester that was not served last wins.
  assign w_pick_b = w_s_b & (~w_s_a | (r_last == SEL_A));
  assign w_g_req  = (r_g == SEL_B) ? w_s_b : w_s_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= SEL_B;
      r_g     <= SEL_A;
      r_oreq  <= 1'b0;
      r_aack  <= 1'b0;
      r_back  <= 1'b0;
      r_odata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_g     <= w_pick_b;
            r_last  <= w_pick_b;
            r_odata <= w_pick_b ? b_data : a_data;
            r_oreq  <= 1'b1;
            r_state <= OREQ;
          end
        end
        OREQ: begin
          if (w_s_oack) begin
            if (r_g == SEL_B) r_back <= 1'b1;
            else              r_aack <= 1'b1;
            r_state <= SACK;
          end
        end
        SACK: begin
          if (!w_g_req) begin
            r_oreq  <= 1'b0;
            r_state <= OREL;
          end
        end
        OREL: begin
          if (!w_s_oack) begin
            r_aack  <= 1'b0;
            r_back  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a_ack  = r_aack;
  assign b_ack  = r_back;
  assign o_req  = r_oreq;
  assign o_data = r_odata;

endmodule

// File: tb/tb_tokenflow_arbiter.sv
// Self-checking bench for tokenflow_arbiter: directed handshakes plus
// randomized two-requester traffic checked against per-requester FIFOs.
module tb_tokenflow_arbiter;

`ifdef TOKENFLOW_ARBITER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int W = 15;
  localparam int TMO = 400;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_req;
  logic [W-1:0] a_data;
  logic         a_ack;
  logic         b_req;
  logic [W-1:0] b_data;
  logic         b_ack;
  logic         o_req;
  logic [W-1:0] o_data;
  logic         o_ack;
  logic         tie;
  logic         o_ack_man;

  int n_chk = 0;
  int n_fail = 0;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  assign o_ack = tie ? o_req : o_ack_man;

  always #5 clk = ~clk;

  tokenflow_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_req (a_req),
    .a_data(a_data),
    .a_ack (a_ack),
    .b_req (b_req),
    .b_data(b_data),
    .b_ack (b_ack),
    .o_req (o_req),
    .o_data(o_data),
    .o_ack (o_ack)
  );

  // One four-phase transfer from requester A; must be called at a negedge.
  task automatic do_a(input logic [W-1:0] d);
    int c;
    a_data = d;
    a_req = 1'b1;
    c = 0;
    while (a_ack !== 1'b1 && c < TMO) begin @(negedge clk); c++; end
    n_chk++;
    if (a_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL a_ack_rise: got %b want 1", a_ack);
    end
    a_req = 1'b0;
    c = 0;
    while (a_ack !== 1'b0 && c < TMO) begin @(negedge clk); c++; end
    n_chk++;
    if (a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL a_ack_fall: got %b want 0", a_ack);
    end
  endtask

  task automatic do_b(input logic [W-1:0] d);
    int c;
    b_data = d;
    b_req = 1'b1;
    c = 0;
    while (b_ack !== 1'b1 && c < TMO) begin @(negedge clk); c++; end
    n_chk++;
    if (b_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL b_ack_rise: got %b want 1", b_ack);
    end
    b_req = 1'b0;
    c = 0;
    while (b_ack !== 1'b0 && c < TMO) begin @(negedge clk); c++; end
    n_chk++;
    if (b_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL b_ack_fall: got %b want 0", b_ack);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tie = 1'b1;
    o_ack_man = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    a_data = '0;
    b_data = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (o_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_oreq: got %b want 0", o_req);
    end
    n_chk++;
    if ({a_ack, b_ack} !== 2'b00) begin
      n_fail++; $display("FAIL reset_acks: got %b want 00", {a_ack, b_ack});
    end
    n_chk++;
    if (o_data !== '0) begin
      n_fail++; $display("FAIL reset_odata: got %h want 0", o_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Both requesters contend from reset: grants alternate starting with A.
  task automatic test_tie;
    logic [W-1:0] seen[$];
    logic [W-1:0] exp[$];
    for (int i = 0; i < 3; i++) exp.push_back((i % 2 == 0) ? 15'h0001 : 15'h0002);
    fork
      begin do_a(15'h0001); do_a(15'h0001); end
      do_b(15'h0002);
      begin
        logic prev;
        prev = o_req;
        for (int c = 0; c < 3 * TMO && seen.size() < 3; c++) begin
          @(negedge clk);
          if (o_req && !prev) seen.push_back(o_data);
          prev = o_req;
        end
      end
    join
    n_chk++;
    if (seen.size() != 3) begin
      n_fail++; $display("FAIL tie_count: got %0d want 3", seen.size());
    end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_chk++;
      if (seen[i] !== exp[i]) begin
        n_fail++; $display("FAIL tie_order[%0d]: got %h want %h", i, seen[i], exp[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    logic bseen;
    int c;
    bseen = 1'b0;
    a_data = 15'h1234;
    a_req = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    n_chk++;
    if (o_req !== 1'b0) begin
      n_fail++; $display("FAIL single_early: got o_req %b want 0", o_req);
    end
    @(negedge clk);
    n_chk++;
    if ({o_req, o_data} !== {1'b1, 15'h1234}) begin
      n_fail++; $display("FAIL single_oreq: got %b/%h want 1/1234", o_req, o_data);
    end
    c = 0;
    while (a_ack !== 1'b1 && c < TMO) begin
      bseen |= b_ack;
      @(negedge clk); c++;
    end
    n_chk++;
    if (a_ack !== 1'b1) begin
      n_fail++; $display("FAIL single_ack: got %b want 1", a_ack);
    end
    a_req = 1'b0;
    c = 0;
    while ((o_req !== 1'b0 || a_ack !== 1'b0) && c < TMO) begin
      bseen |= b_ack;
      @(negedge clk); c++;
    end
    n_chk++;
    if ({o_req, a_ack} !== 2'b00) begin
      n_fail++; $display("FAIL single_release: got %b want 00", {o_req, a_ack});
    end
    n_chk++;
    if (bseen !== 1'b0) begin
      n_fail++; $display("FAIL single_back: got %b want 0", bseen);
    end
    @(negedge clk);
  endtask

  task automatic test_holdoff;
    int c;
    tie = 1'b0;
    o_ack_man = 1'b0;
    a_data = 15'h0ABC;
    a_req = 1'b1;
    repeat (LAT) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if ({o_req, a_ack, o_data} !== {1'b1, 1'b0, 15'h0ABC}) begin
        n_fail++;
        $display("FAIL holdoff[%0d]: got %b/%b/%h want 1/0/0abc", i, o_req, a_ack, o_data);
      end
      @(negedge clk);
    end
    o_ack_man = 1'b1;
    c = 0;
    while (a_ack !== 1'b1 && c < TMO) begin @(negedge clk); c++; end
    n_chk++;
    if (a_ack !== 1'b1) begin
      n_fail++; $display("FAIL holdoff_ack: got %b want 1", a_ack);
    end
    a_req = 1'b0;
    c = 0;
    while (o_req !== 1'b0 && c < TMO) begin @(negedge clk); c++; end
    n_chk++;
    if ({o_req, a_ack} !== 2'b01) begin
      n_fail++; $display("FAIL holdoff_oreq_fall: got %b want 01", {o_req, a_ack});
    end
    o_ack_man = 1'b0;
    c = 0;
    while (a_ack !== 1'b0 && c < TMO) begin @(negedge clk); c++; end
    n_chk++;
    if (a_ack !== 1'b0) begin
      n_fail++; $display("FAIL holdoff_ack_fall: got %b want 0", a_ack);
    end
    tie = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int c;
    a_data = 15'h0007;
    a_req = 1'b1;
    c = 0;
    while (a_ack !== 1'b1 && c < TMO) begin @(negedge clk); c++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    a_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({o_req, a_ack, b_ack, o_data} !== '0) begin
      n_fail++;
      $display("FAIL midreset: got %b/%b/%b/%h want 0/0/0/0", o_req, a_ack, b_ack, o_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    a_data = 15'h0001;
    b_data = 15'h0002;
    a_req = 1'b1;
    b_req = 1'b1;
    repeat (LAT) @(negedge clk);
    n_chk++;
    if ({o_req, o_data} !== {1'b1, 15'h0001}) begin
      n_fail++; $display("FAIL midreset_tie: got %b/%h want 1/0001", o_req, o_data);
    end
    fork
      do_a(15'h0001);
      do_b(15'h0002);
    join
    @(negedge clk);
  endtask

  task automatic test_random;
    int na;
    int nb;
    na = 0;
    nb = 0;
    qa.delete();
    qb.delete();
    fork
      for (int i = 0; i < 50; i++) begin
        logic [W-1:0] d;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        d = W'($urandom);
        qa.push_back(d);
        do_a(d);
      end
      for (int i = 0; i < 50; i++) begin
        logic [W-1:0] d;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        d = W'($urandom);
        qb.push_back(d);
        do_b(d);
      end
      begin
        logic pa;
        logic pb;
        logic [W-1:0] want;
        pa = a_ack;
        pb = b_ack;
        for (int c = 0; c < 20000 && (na + nb) < 100; c++) begin
          @(negedge clk);
          n_chk++;
          if (a_ack && b_ack) begin
            n_fail++; $display("FAIL rand_mutex: got a=%b b=%b want not both", a_ack, b_ack);
          end
          if (a_ack && !pa) begin
            want = (qa.size() > 0) ? qa.pop_front() : 'x;
            n_chk++;
            if (o_data !== want) begin
              n_fail++; $display("FAIL rand_a_data: got %h want %h", o_data, want);
            end
            na++;
          end
          if (b_ack && !pb) begin
            want = (qb.size() > 0) ? qb.pop_front() : 'x;
            n_chk++;
            if (o_data !== want) begin
              n_fail++; $display("FAIL rand_b_data: got %h want %h", o_data, want);
            end
            nb++;
          end
          pa = a_ack;
          pb = b_ack;
        end
      end
    join
    n_chk++;
    if (na != 50 || nb != 50) begin
      n_fail++; $display("FAIL rand_count: got %0d/%0d want 50/50", na, nb);
    end
  endtask

  initial begin
    test_reset;
    test_tie;
    test_single;
    test_holdoff;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tokenflow_arbiter.md
TOKENFLOW_ARBITER -- requirements
Module: tokenflow_arbiter

Interface
REQ-001 Parameter: W, 15, bundled-data width of every channel.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: a_req  input  1  requester A request, four-phase, asynchronous to clk.
REQ-005 Port: a_data  input  W  requester A data, stable while a_req high.
REQ-006 Port: a_ack  output  1  requester A acknowledge, registered.
REQ-007 Port: b_req  input  1  requester B request, four-phase, asynchronous to clk.
REQ-008 Port: b_data  input  W  requester B data, stable while b_req high.
REQ-009 Port: b_ack  output  1  requester B acknowledge, registered.
REQ-010 Port: o_req  output  1  shared output channel request, registered.
REQ-011 Port: o_data  output  W  shared output channel data, registered.
REQ-012 Port: o_ack  input  1  shared output channel acknowledge, asynchronous to clk.

Function
REQ-013 All channels SHALL use four-phase bundled data: req rise, ack rise, req fall, ack fall.
REQ-014 Sampled inputs s_a_req, s_b_req, s_o_ack SHALL be the raw inputs delayed by the input stage (see Configuration); FSM decisions use only sampled values.
REQ-015 FSM states SHALL be IDLE, OREQ, SACK, OREL, with one grant register g (A or B) and one round-robin pointer last (A or B).
REQ-016 IDLE: if exactly one sampled req high, grant it; if both high, grant the requester other than last; on grant latch that requester's data into o_data, set g, set last=g, set o_req=1, go OREQ.
REQ-017 IDLE with no sampled req high: hold all outputs, stay IDLE.
REQ-018 OREQ: when s_o_ack=1, set ack of g to 1, go SACK; otherwise hold.
REQ-019 SACK: when sampled req of g is 0, set o_req=0, go OREL; otherwise hold.
REQ-020 OREL: when s_o_ack=0, set ack of g to 0, go IDLE; otherwise hold.
REQ-021 o_data SHALL change only on the IDLE->OREQ edge; it is stable from o_req rise until next grant.
REQ-022 At most one of a_ack, b_ack SHALL be high at any time; the non-granted ack stays 0.
REQ-023 A requester's req changes while not granted SHALL be ignored until IDLE; a req that drops before grant is never served.
REQ-024 The minimum IDLE dwell SHALL be one cycle: after OREL->IDLE a new grant occurs no earlier than the following edge.
REQ-025 Under continuous contention with both reqs held high (re-raised after ack fall), grants SHALL strictly alternate A,B,A,B.

Reset
REQ-026 While rst_n=0 at a clock edge: state=IDLE, last=B, g=A, o_req=0, a_ack=0, b_ack=0, o_data=0, input stage cleared to 0.
REQ-027 Reset asserted mid-transaction SHALL abandon it with outputs as REQ-026 on the next edge; no completion handshake is issued.
REQ-028 After reset, the first tie SHALL grant A.

Configuration
REQ-029 Macro TOKENFLOW_ARBITER_SYNC_EN: when defined, a_req, b_req, o_ack each pass through a two-flop synchronizer (sampled value = raw value two edges earlier).
REQ-030 Without TOKENFLOW_ARBITER_SYNC_EN, sampled value = raw value at the current edge (no added latency); intended for synchronous benches only.
REQ-031 Request-to-o_req latency SHALL be 1 edge without the macro and 3 edges with it; same offset applies to every FSM step.

Verification
REQ-032 Single A transfer, macro off: a_data=0x1234, a_req=1, o_ack tied to o_req -> o_req rises 1 edge later with o_data=0x1234, a_ack rises, completes full four-phase, b_ack stays 0.
REQ-033 Tie after reset: a_req=b_req=1 same edge, a_data=0x0001, b_data=0x0002 -> first o_data=0x0001, second o_data=0x0002, third 0x0001.
REQ-034 Hold-off: o_ack held 0 for 10 cycles after o_req rise -> FSM stays OREQ, a_ack=0, o_data unchanged; o_ack=1 then completes.
REQ-035 Reset mid-op: assert rst_n=0 while in SACK -> next edge o_req=0, a_ack=b_ack=0, o_data=0; after release, tie grants A.
REQ-036 Macro on: a_req rises before edge k -> o_req high after edge k+2; a_ack high 3 edges after o_ack rise; 100 random-gap transfers preserve data order per requester and mutual-exclusive acks.
